// File: rtl/wisard_ctrl_pkg.sv
// Shared types for the wisard sample sequencer and its tester:
// FSM state enum, result bundle and default field widths.
package wisard_ctrl_pkg;

   localparam int CLASS_WIDTH_DEF = 1;
   localparam int TAG_WIDTH_DEF   = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_WAIT,
      ST_RESP
   } seq_state_e;

   typedef struct packed {
      logic [CLASS_WIDTH_DEF-1:0] cls;
      logic [TAG_WIDTH_DEF-1:0]   tag;
      logic                       timeout;
   } wisard_res_t;

endpackage

// File: rtl/wisard_bit_serializer.sv
// Shift register + index counter streaming a sample LSB-first.
// Ports: i_load/i_data start a burst; o_sop, o_tuple_valid,
// o_tuple_bit go to the core; o_last flags the final bit.
module wisard_bit_serializer #(
   parameter int SAMPLE_BITS = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_load,
   input  logic [SAMPLE_BITS-1:0] i_data,
   output logic                   o_sop,
   output logic                   o_tuple_valid,
   output logic                   o_tuple_bit,
   output logic                   o_last
);

   localparam int IW = $clog2(SAMPLE_BITS);
   localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLE_BITS - 1);

   logic [SAMPLE_BITS-1:0] r_shift;
   logic [IW-1:0]          r_idx;
   logic                   r_tv;
   logic                   r_sop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift <= '0;
         r_idx   <= '0;
         r_tv    <= 1'b0;
         r_sop   <= 1'b0;
      end else if (i_load) begin
         r_shift <= i_data;
         r_idx   <= '0;
         r_tv    <= 1'b1;
         r_sop   <= 1'b1;
      end else if (r_tv) begin
         r_shift <= r_shift >> 1;
         r_sop   <= 1'b0;
         if (r_idx == LAST_IDX) begin
            r_idx <= '0;
            r_tv  <= 1'b0;
         end else begin
            r_idx <= r_idx + IW'(1);
         end
      end
   end

   // Bit 0 of the shifter is always the bit currently on the wire.
   assign o_tuple_bit   = r_shift[0];
   assign o_tuple_valid = r_tv;
   assign o_sop         = r_sop;
   assign o_last        = r_tv && (r_idx == LAST_IDX);

endmodule

// File: rtl/wisard_sample_sequencer.sv
// Sequencer: accepts a sample, streams it to the wisard core,
// waits for a prediction (with timeout) and returns a tagged
// result. Ports: s_* request in, sop/tuple_* to core,
// prediction_* from core, r_* result out, status/counters.
module wisard_sample_sequencer
   import wisard_ctrl_pkg::*;
#(
   parameter int SAMPLE_BITS    = 64,
   parameter int CLASS_WIDTH    = CLASS_WIDTH_DEF,
   parameter int TAG_WIDTH      = TAG_WIDTH_DEF,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [SAMPLE_BITS-1:0] s_data,
   input  logic [TAG_WIDTH-1:0]   s_tag,
   output logic                   sop,
   output logic                   tuple_valid,
   output logic                   tuple_bit,
   input  logic                   prediction_valid,
   input  logic [CLASS_WIDTH-1:0] predicted_class,
   output logic                   r_valid,
   input  logic                   r_ready,
   output logic [CLASS_WIDTH-1:0] r_class,
   output logic [TAG_WIDTH-1:0]   r_tag,
   output logic                   r_timeout,
   output logic                   busy,
   output logic                   err_spurious,
   output logic [CNT_WIDTH-1:0]   cnt_done,
   output logic [CNT_WIDTH-1:0]   cnt_timeout
);

   localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMW-1:0] TMO_LAST = TMW'(TIMEOUT_CYCLES - 1);

   seq_state_e r_state;
   seq_state_e w_next;

   logic                   w_s_ready;
   logic                   w_busy;
   logic                   w_r_valid;
   logic                   w_load;
   logic                   w_last;
   logic                   w_pv_hit;
   logic                   w_tmo_hit;

   logic [TMW-1:0]         r_tmo;
   logic [TAG_WIDTH-1:0]   r_tag_hold;
   logic [CLASS_WIDTH-1:0] r_res_class;
   logic [TAG_WIDTH-1:0]   r_res_tag;
   logic                   r_res_to;
   logic                   r_err;
   logic [CNT_WIDTH-1:0]   r_cnt_done;
   logic [CNT_WIDTH-1:0]   r_cnt_tmo;

   wisard_bit_serializer #(
      .SAMPLE_BITS (SAMPLE_BITS)
   ) u_ser (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_load        (w_load),
      .i_data        (s_data),
      .o_sop         (sop),
      .o_tuple_valid (tuple_valid),
      .o_tuple_bit   (tuple_bit),
      .o_last        (w_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_s_ready = 1'b0;
      w_busy    = 1'b1;
      w_r_valid = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_s_ready = 1'b1;
            w_busy    = 1'b0;
            if (s_valid) w_next = ST_STREAM;
         end
         ST_STREAM: begin
            if (w_last) w_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (w_pv_hit || w_tmo_hit) w_next = ST_RESP;
         end
         ST_RESP: begin
            w_r_valid = 1'b1;
            if (r_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign w_load    = s_valid && w_s_ready;
   assign w_pv_hit  = (r_state == ST_WAIT) && prediction_valid;
   // A prediction on the limit cycle wins over the timeout.
   assign w_tmo_hit = (r_state == ST_WAIT) && !prediction_valid
                      && (r_tmo == TMO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo       <= '0;
         r_tag_hold  <= '0;
         r_res_class <= '0;
         r_res_tag   <= '0;
         r_res_to    <= 1'b0;
         r_err       <= 1'b0;
         r_cnt_done  <= '0;
         r_cnt_tmo   <= '0;
      end else begin
         if (w_load) r_tag_hold <= s_tag;
         if (r_state == ST_WAIT) r_tmo <= r_tmo + TMW'(1);
         else                    r_tmo <= '0;
         if (w_pv_hit) begin
            r_res_class <= predicted_class;
            r_res_tag   <= r_tag_hold;
            r_res_to    <= 1'b0;
            if (r_cnt_done != '1)
               r_cnt_done <= r_cnt_done + CNT_WIDTH'(1);
         end else if (w_tmo_hit) begin
            r_res_class <= '0;
            r_res_tag   <= r_tag_hold;
            r_res_to    <= 1'b1;
            if (r_cnt_tmo != '1)
               r_cnt_tmo <= r_cnt_tmo + CNT_WIDTH'(1);
         end
         if (prediction_valid && (r_state != ST_WAIT))
            r_err <= 1'b1;
      end
   end

   assign s_ready      = w_s_ready;
   assign busy         = w_busy;
   assign r_valid      = w_r_valid;
   assign r_class      = r_res_class;
   assign r_tag        = r_res_tag;
   assign r_timeout    = r_res_to;
   assign err_spurious = r_err;
   assign cnt_done     = r_cnt_done;
   assign cnt_timeout  = r_cnt_tmo;

endmodule

// File: tb/tb_wisard_sample_sequencer.sv
// Self-checking bench for wisard_sample_sequencer: timeline
// reference model, per-cycle compare, directed + random stimulus.
module tb_wisard_sample_sequencer;
   import wisard_ctrl_pkg::*;

   localparam int N  = 8;
   localparam int TO = 16;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [N-1:0]  s_data = '0;
   logic [3:0]    s_tag = '0;
   logic          sop, tuple_valid, tuple_bit;
   logic          prediction_valid = 1'b0;
   logic [0:0]    predicted_class = '0;
   logic          r_valid;
   logic          r_ready = 1'b0;
   logic [0:0]    r_class;
   logic [3:0]    r_tag;
   logic          r_timeout, busy, err_spurious;
   logic [CW-1:0] cnt_done, cnt_timeout;

   always #5 clk = ~clk;

   wisard_sample_sequencer #(
      .SAMPLE_BITS    (N),
      .CLASS_WIDTH    (1),
      .TAG_WIDTH      (4),
      .TIMEOUT_CYCLES (TO),
      .CNT_WIDTH      (CW)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .s_valid          (s_valid),
      .s_ready          (s_ready),
      .s_data           (s_data),
      .s_tag            (s_tag),
      .sop              (sop),
      .tuple_valid      (tuple_valid),
      .tuple_bit        (tuple_bit),
      .prediction_valid (prediction_valid),
      .predicted_class  (predicted_class),
      .r_valid          (r_valid),
      .r_ready          (r_ready),
      .r_class          (r_class),
      .r_tag            (r_tag),
      .r_timeout        (r_timeout),
      .busy             (busy),
      .err_spurious     (err_spurious),
      .cnt_done         (cnt_done),
      .cnt_timeout      (cnt_timeout)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Timeline model: edge count since acceptance decides phase.
   int            cyc = 0;
   int            m_T = 0;
   logic          m_busy = 0, m_res = 0, m_to = 0, m_spur = 0;
   logic [N-1:0]  m_data = '0;
   logic [3:0]    m_tagh = '0;
   wisard_res_t   m_r = '0;
   logic [CW-1:0] m_done = '0, m_tmo = '0;

   always @(posedge clk or negedge rst_n) begin : model
      int k;
      if (!rst_n) begin
         cyc <= 0; m_T <= 0; m_busy <= 0; m_res <= 0; m_to <= 0;
         m_spur <= 0; m_data <= '0; m_tagh <= '0; m_r <= '0;
         m_done <= '0; m_tmo <= '0;
      end else begin
         cyc <= cyc + 1;
         k = cyc + 1 - m_T;
         if (!m_busy) begin
            if (prediction_valid) m_spur <= 1'b1;
            if (s_valid) begin
               m_busy <= 1'b1;
               m_T    <= cyc + 1;
               m_data <= s_data;
               m_tagh <= s_tag;
            end
         end else if (!m_res) begin
            if (k <= N) begin
               if (prediction_valid) m_spur <= 1'b1;
            end else if (prediction_valid) begin
               m_res <= 1'b1;
               m_r   <= '{cls: predicted_class, tag: m_tagh, timeout: 1'b0};
               if (m_done != '1) m_done <= m_done + 1'b1;
            end else if (k == N + TO) begin
               m_res <= 1'b1;
               m_r   <= '{cls: 1'b0, tag: m_tagh, timeout: 1'b1};
               if (m_tmo != '1) m_tmo <= m_tmo + 1'b1;
            end
         end else begin
            if (prediction_valid) m_spur <= 1'b1;
            if (r_ready) begin
               m_busy <= 1'b0;
               m_res  <= 1'b0;
            end
         end
      end
   end

   logic [N-1:0] seen = '0;
   int           seen_n = 0;

   always @(negedge clk) begin : cmp
      int   k;
      logic tv;
      k  = cyc - m_T;
      tv = m_busy && !m_res && (k >= 0) && (k < N);
      chk("s_ready", s_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("tuple_valid", tuple_valid, tv);
      chk("sop", sop, tv && (k == 0));
      if (tv) chk("tuple_bit", tuple_bit, m_data[k]);
      chk("r_valid", r_valid, m_res);
      if (m_res) begin
         chk("r_class", r_class, m_r.cls);
         chk("r_tag", r_tag, m_r.tag);
         chk("r_timeout", r_timeout, m_r.timeout);
      end
      chk("err_spurious", err_spurious, m_spur);
      chk("cnt_done", cnt_done, m_done);
      chk("cnt_timeout", cnt_timeout, m_tmo);
      if (tuple_valid) begin
         if (sop) begin
            seen[0] <= tuple_bit;
            seen_n  <= 1;
         end else if (seen_n < N) begin
            seen[seen_n] <= tuple_bit;
            seen_n       <= seen_n + 1;
         end
      end
   end

   // Offer a sample, stream it, and answer after pvd wait cycles
   // (0 = never). spur pulses prediction_valid at edge T+spur.
   task automatic start(input logic [N-1:0] d, input logic [3:0] tg,
                        input int pvd, input logic cls,
                        input int spur, output int lat);
      int w;
      w = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_tag   = tg;
      while (!s_ready && w < 60) begin
         @(posedge clk); #2;
         w++;
      end
      if (!s_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL accept: s_ready=0 after %0d cycles, need 1", w);
      end
      @(posedge clk); #2;
      s_valid = 1'b0;
      s_data  = N'($urandom);
      s_tag   = 4'($urandom);
      lat = -1;
      for (int j = 1; j <= N + TO + 4; j++) begin
         prediction_valid = ((pvd > 0) && (j == N + pvd)) || (j == spur);
         predicted_class  = ((pvd > 0) && (j == N + pvd)) ?
                            cls : 1'($urandom);
         @(posedge clk); #2;
         prediction_valid = 1'b0;
         if (r_valid) begin
            lat = j - N;
            break;
         end
      end
      if (lat < 0) begin
         n_cmp++; n_bad++;
         $display("FAIL result: r_valid=0 after budget, need 1");
      end
   endtask

   task automatic complete(input int rdly, input logic hold_v,
                           input logic noise);
      s_valid = hold_v;
      for (int i = 0; i < rdly; i++) begin
         prediction_valid = noise && ($urandom_range(0, 3) == 0);
         @(posedge clk); #2;
         prediction_valid = 1'b0;
      end
      r_ready = 1'b1;
      @(posedge clk); #2;
      r_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin : main
      int lat;
      logic [N-1:0] d;
      int pvd, spur;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_s_ready", s_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_tv", tuple_valid, 0);
      chk("rst_cnt", cnt_done, 0);
      rst_n = 1'b1;

      start(8'hA5, 4'd3, 3, 1'b1, -1, lat);
      chk("t1_lat", lat, 3);
      chk("t1_bits", seen, 8'hA5);
      chk("t1_class", r_class, 1);
      chk("t1_tag", r_tag, 3);
      chk("t1_to", r_timeout, 0);
      chk("t1_done", cnt_done, 1);
      complete(0, 1'b0, 1'b0);

      do_reset();
      start(8'hA5, 4'd3, 0, 1'b1, -1, lat);
      chk("t2_lat", lat, 16);
      chk("t2_to", r_timeout, 1);
      chk("t2_class", r_class, 0);
      chk("t2_ctmo", cnt_timeout, 1);
      chk("t2_done", cnt_done, 0);
      complete(2, 1'b0, 1'b0);

      start(8'h5A, 4'd9, TO, 1'b1, -1, lat);
      chk("t3_lat", lat, 16);
      chk("t3_to", r_timeout, 0);
      chk("t3_class", r_class, 1);
      chk("t3_done", cnt_done, 1);
      chk("t3_ctmo", cnt_timeout, 1);
      complete(0, 1'b0, 1'b0);

      start(8'hC3, 4'd7, 2, 1'b0, -1, lat);
      s_valid = 1'b1;
      s_data  = 8'h96;
      s_tag   = 4'd2;
      repeat (20) @(posedge clk);
      #2;
      chk("t4_sready", s_ready, 0);
      chk("t4_tag", r_tag, 7);
      chk("t4_class", r_class, 0);
      complete(0, 1'b1, 1'b0);
      chk("t4_idle", s_ready, 1);
      start(8'h96, 4'd2, 5, 1'b1, -1, lat);
      chk("t4_bits", seen, 8'h96);
      chk("t4_tag2", r_tag, 2);
      complete(1, 1'b0, 1'b0);

      chk("t5_err0", err_spurious, 0);
      start(8'hF0, 4'd4, 4, 1'b0, 5, lat);
      chk("t5_err", err_spurious, 1);
      chk("t5_bits", seen, 8'hF0);
      chk("t5_lat", lat, 4);
      chk("t5_tag", r_tag, 4);
      complete(0, 1'b0, 1'b0);
      chk("t5_sticky", err_spurious, 1);

      s_valid = 1'b1;
      s_data  = 8'hE7;
      s_tag   = 4'd1;
      @(posedge clk); #2;
      s_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_tv", tuple_valid, 0);
      chk("t6_sop", sop, 0);
      chk("t6_busy", busy, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      chk("t6_sready", s_ready, 1);
      chk("t6_done", cnt_done, 0);
      chk("t6_err", err_spurious, 0);
      start(8'h3C, 4'd5, 2, 1'b1, -1, lat);
      chk("t6_bits", seen, 8'h3C);
      complete(0, 1'b0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         d    = N'($urandom);
         pvd  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, TO);
         spur = ($urandom_range(0, 3) == 0) ? $urandom_range(1, N) : -1;
         start(d, 4'($urandom), pvd, 1'($urandom), spur, lat);
         chk("rnd_bits", seen, d);
         chk("rnd_lat", lat, (pvd == 0) ? TO : pvd);
         complete($urandom_range(0, 4), 1'($urandom), 1'b1);
      end

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
